// File: rtl/multi_word_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multi_word_add_sequencer
// Purpose  : Feeds an external WIDTH-bit adder one slice per cycle, chaining
//            the carry across WORDS slices and registering each result slice.
// Revision : 1.0  initial release
// ============================================================================
module multi_word_add_sequencer #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic             in_carry,
    output logic [WIDTH-1:0] adder_data_1,
    output logic [WIDTH-1:0] adder_data_2,
    output logic             adder_carry_in,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_carry,
    output logic             busy
);

    localparam int              C_CW   = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WORDS - 1);

    logic [C_CW-1:0] r_slice_cnt;
    logic            r_carry;
    logic            w_accept;
    logic            w_first;
    logic            w_last;

    assign w_first        = (r_slice_cnt == '0);
    assign w_last         = (r_slice_cnt == C_LAST);
    assign in_ready       = !out_valid || out_ready;
    assign w_accept       = in_valid && in_ready;
    assign busy           = !w_first;

    assign adder_data_1   = in_data_1;
    assign adder_data_2   = in_data_2;
    // The operation carry-in only enters on the first slice; later slices chain.
    assign adder_carry_in = w_first ? in_carry : r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slice_cnt <= '0;
            r_carry     <= 1'b0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_last    <= 1'b0;
            out_carry   <= 1'b0;
        end else if (w_accept) begin
            out_sum     <= adder_sum;
            r_carry     <= adder_carry_out;
            out_valid   <= 1'b1;
            out_last    <= w_last;
            out_carry   <= w_last ? adder_carry_out : 1'b0;
            r_slice_cnt <= w_last ? '0 : r_slice_cnt + C_CW'(1);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_word_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_word_add_sequencer
// Purpose  : Table-driven and random checks of the slice sequencer with a
//            behavioural adder and an expected-slice queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_word_add_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data_1 = '0;
    logic [3:0] in_data_2 = '0;
    logic       in_carry = 1'b0;
    logic [3:0] adder_data_1;
    logic [3:0] adder_data_2;
    logic       adder_carry_in;
    logic [3:0] adder_sum;
    logic       adder_carry_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_last;
    logic       out_carry;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic rnd_bit = 1'b1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [3:0] s;
        logic       l;
        logic       c;
    } slice_t;

    slice_t exp_q[$];
    vec_t   tbl[8];

    always #5 clk = ~clk;

    // Behavioural model of the attached adder.
    assign {adder_carry_out, adder_sum} = 5'(adder_data_1) + 5'(adder_data_2) + 5'(adder_carry_in);

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign out_ready = (rdy_mode == 0) || (rdy_mode == 1 && rnd_bit);

    multi_word_add_sequencer #(.WIDTH(4), .WORDS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data_1      (in_data_1),
        .in_data_2      (in_data_2),
        .in_carry       (in_carry),
        .adder_data_1   (adder_data_1),
        .adder_data_2   (adder_data_2),
        .adder_carry_in (adder_carry_in),
        .adder_sum      (adder_sum),
        .adder_carry_out(adder_carry_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sum        (out_sum),
        .out_last       (out_last),
        .out_carry      (out_carry),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake happens at the following rising edge when seen here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got sum %0h with empty scoreboard", out_sum);
            end else begin
                slice_t e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.s));
                chk("out_last", 32'(out_last), 32'(e.l));
                chk("out_carry", 32'(out_carry), 32'(e.c));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one slice, wait for acceptance, and record its expected result.
    task automatic put_slice(input logic [3:0] d1, input logic [3:0] d2, input logic c,
                             input int idx, input logic [16:0] full);
        int t;
        slice_t e;
        in_valid  = 1'b1;
        in_data_1 = d1;
        in_data_2 = d2;
        in_carry  = c;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: slice %0d never accepted", idx);
                break;
            end
        end
        chk("busy", 32'(busy), 32'(idx != 0));
        e.s = full[4*idx +: 4];
        e.l = (idx == 3);
        e.c = (idx == 3) ? full[16] : 1'b0;
        exp_q.push_back(e);
        next_cycle();
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [16:0] full, input int stall_pct);
        for (int i = 0; i < 4; i++) begin
            while (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                in_valid = 1'b0;
                next_cycle();
            end
            put_slice(a[4*i +: 4], b[4*i +: 4], (i == 0) ? cin : 1'($urandom_range(0, 1)), i, full);
        end
    endtask

    task automatic drain();
        int t;
        in_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            next_cycle();
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        tbl[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        tbl[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};
        tbl[7] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0};

        repeat (3) next_cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        next_cycle();

        // Back-to-back operations with continuous flow.
        rdy_mode = 0;
        for (int k = 0; k < 8; k++)
            send_op(tbl[k].a, tbl[k].b, tbl[k].cin, {tbl[k].cout, tbl[k].sum}, 0);
        drain();

        // Output stall: first result must hold while downstream is not ready.
        rdy_mode = 2;
        put_slice(4'h4, 4'h1, 1'b1, 0, 17'h05556);
        in_valid  = 1'b1;
        in_data_1 = 4'h3;
        in_data_2 = 4'h2;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'h6);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            next_cycle();
        end
        rdy_mode = 0;
        put_slice(4'h3, 4'h2, 1'b0, 1, 17'h05556);
        put_slice(4'h2, 4'h3, 1'b0, 2, 17'h05556);
        put_slice(4'h1, 4'h4, 1'b1, 3, 17'h05556);
        drain();

        // Reset in the middle of an operation.
        put_slice(4'hF, 4'h1, 1'b0, 0, 17'h10000);
        put_slice(4'hF, 4'h0, 1'b0, 1, 17'h10000);
        in_valid = 1'b0;
        next_cycle();
        chk("mid_busy", 32'(busy), 32'd1);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        send_op(16'h0003, 16'h0004, 1'b0, 17'h00007, 0);
        drain();

        // Random operands with random valid gaps and output back-pressure.
        rdy_mode = 1;
        for (int k = 0; k < 30; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            send_op(ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc), 30);
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_word_add_sequencer.md
MULTI_WORD_ADD_SEQUENCER -- requirements
Module: Multi_Word_Add_Sequencer

Interface
REQ-001 Parameter WIDTH, default 4: bit width of one word slice and of the attached WIDTH-bit adder.
REQ-002 Parameter WORDS, default 4: word slices per operation (minimum 2); operand width = WIDTH*WORDS.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 In_valid  input  1  upstream word pair valid.
REQ-006 In_ready  output  1  block accepts word pair this cycle.
REQ-007 In_data_1  input  WIDTH  operand-1 slice, least significant slice first.
REQ-008 In_data_2  input  WIDTH  operand-2 slice, least significant slice first.
REQ-009 In_carry  input  1  operation carry-in; sampled only on the first slice.
REQ-010 Adder_data_1  output  WIDTH  to adder Data_1; equals In_data_1 (combinational).
REQ-011 Adder_data_2  output  WIDTH  to adder Data_2; equals In_data_2 (combinational).
REQ-012 Adder_carry_in  output  1  to adder Carry_in.
REQ-013 Adder_sum  input  WIDTH  from adder Sum.
REQ-014 Adder_carry_out  input  1  from adder Carry_out.
REQ-015 Out_valid  output  1  result slice valid.
REQ-016 Out_ready  input  1  downstream accepts result slice.
REQ-017 Out_sum  output  WIDTH  registered result slice.
REQ-018 Out_last  output  1  Out_sum is the final (most significant) slice.
REQ-019 Out_carry  output  1  operation carry-out; meaningful only when Out_last=1, else 0.
REQ-020 Busy  output  1  high while a multi-slice operation is partially accepted (slice count != 0).

Function
REQ-021 Slice counter Slice_cnt (0..WORDS-1) defines states: FIRST (Slice_cnt=0) and NEXT (Slice_cnt!=0).
REQ-022 Adder_carry_in = In_carry in FIRST; = registered Carry_reg in NEXT.
REQ-023 In_ready = !Out_valid || Out_ready (one-entry output register, no bubble under continuous flow).
REQ-024 Accept event = In_valid && In_ready.
REQ-025 On accept: Out_sum <= Adder_sum, Carry_reg <= Adder_carry_out, Out_valid <= 1, Out_last <= (Slice_cnt==WORDS-1), Out_carry <= (Slice_cnt==WORDS-1) ? Adder_carry_out : 0.
REQ-026 On accept: Slice_cnt increments; wraps from WORDS-1 to 0 (back to FIRST) in the same edge.
REQ-027 Latency: accepted slice appears on Out_sum the next cycle; throughput one slice per cycle.
REQ-028 Out_valid && !Out_ready: Out_sum, Out_last, Out_carry, Out_valid held stable; In_ready=0; no accept.
REQ-029 Out_valid && Out_ready && !accept: Out_valid <= 0 next cycle; other outputs hold.
REQ-030 Out_valid && Out_ready && accept in same cycle: new slice replaces old; Out_valid stays 1.
REQ-031 In_carry ignored in NEXT state; In_valid low in any state leaves Slice_cnt and Carry_reg unchanged (operation may stall between slices indefinitely).
REQ-032 Carry_reg value after the last slice is don't-care; never used by the following FIRST slice.

Reset
REQ-033 Rst_n low asynchronously clears: Slice_cnt=0, Carry_reg=0, Out_valid=0, Out_sum=0, Out_last=0, Out_carry=0; thus Busy=0, In_ready=1.
REQ-034 Reset mid-operation discards the partial operation; the first accepted slice after release is treated as FIRST.
REQ-035 Reset release is synchronized externally; no accept occurs while Rst_n is low.

Verification (WIDTH=4, WORDS=4)
REQ-036 0xFFFF + 0x0001, In_carry=0, Out_ready=1 -> Out_sum 0,0,0,0; Out_last only on 4th; Out_carry=1.
REQ-037 0x1234 + 0x4321, In_carry=1 -> Out_sum 6,5,5,5 (0x5556); Out_carry=0; Busy high after slices 1-3.
REQ-038 Out_ready=0 for 3 cycles after first result -> Out_sum held, In_ready=0, slice not dropped or duplicated.
REQ-039 Rst_n pulsed after 2 slices of 0xFFFF+0x0001, then 0x0003+0x0004 -> result 0x0007, Out_carry=0.
REQ-040 Two back-to-back ops (0x8000+0x8000 then 0x0000+0x0000, In_carry=0) with In_valid=Out_ready=1 -> 8 consecutive results; op1 Out_carry=1, op2 all zero slices with Out_carry=0 (no carry leak).
REQ-041 Random operands/carry, random In_valid/Out_ready -> concatenated result and carry equal the reference 16-bit sum.
